// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexes a 32-bit value as 8 hex digits onto a shared 7-segment bus.
//   A shadow register ("shown") is committed only at a frame boundary, so a digit
//   never changes in the middle of a scan frame. A value captured by update waits
//   in pend_val until that boundary. An update on the boundary cycle itself is
//   written straight into shown.
//
//   Optional build macro: SEG_SCAN_LEADING_ZERO_BLANK_EN
//     When defined, leading zero digits of shown are blanked. Digit 0 always
//     shows its value. The decimal point still follows dp_mask.
//
// Parameters
//   CLK_DIV       CP cycles per digit slot (>= 2)
//   BLANK_CYCLES  display_en low cycles at the start of each slot (1 .. CLK_DIV-1)
//
// Ports
//   CP            system clock, rising edge
//   reset         synchronous, active-high reset
//   data[31:0]    value to display; digit i is data[4i+3:4i]
//   update        one-cycle capture strobe for data
//   dp_mask[7:0]  per-digit decimal point, sampled live
//   display_seg   {dp,g,f,e,d,c,b,a}, active-high
//   display_en    digit-driver enable, active-high
//   display_ctrl  index of the selected digit
//   pending       a captured value is waiting for the frame boundary
module seg_scan_display #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic        CP,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        update,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  display_seg,
    output logic        display_en,
    output logic [2:0]  display_ctrl,
    output logic        pending
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt, cnt_next;
    logic [2:0]       idx, idx_next;
    logic [31:0]      shown, shown_next;
    logic [31:0]      pend_val, pend_val_next;
    logic             pending_next;
    logic             slot_end, frame_end;
    logic [3:0]       nib_next;
    logic [6:0]       gbits_next;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 3'd7);

    always_comb begin
        cnt_next      = cnt;
        idx_next      = idx;
        shown_next    = shown;
        pend_val_next = pend_val;
        pending_next  = pending;
        if (reset) begin
            cnt_next      = '0;
            idx_next      = 3'd0;
            shown_next    = 32'h0;
            pend_val_next = 32'h0;
            pending_next  = 1'b0;
        end else begin
            cnt_next = slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx_next = idx + 3'd1;
            end
            if (update) begin
                pend_val_next = data;
                pending_next  = 1'b1;
            end
            // Frame boundary: a same-cycle update bypasses pend_val.
            if (frame_end) begin
                pending_next = 1'b0;
                if (update) begin
                    shown_next = data;
                end else if (pending) begin
                    shown_next = pend_val;
                end
            end
        end
    end

    // Outputs are built from next-state values so seg, en and ctrl always
    // describe the slot the counters are about to enter.
    always_comb begin
        nib_next   = shown_next[{idx_next, 2'b00} +: 4];
        gbits_next = hex7(nib_next);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        if ((idx_next != 3'd0) && ((shown_next >> {idx_next, 2'b00}) == 32'h0)) begin
            gbits_next = 7'h00;
        end
`endif
    end

    always_ff @(posedge CP) begin
        cnt      <= cnt_next;
        idx      <= idx_next;
        shown    <= shown_next;
        pend_val <= pend_val_next;
        pending  <= pending_next;
        if (reset) begin
            display_seg  <= 8'h00;
            display_en   <= 1'b0;
            display_ctrl <= 3'd0;
        end else begin
            display_seg  <= {dp_mask[idx_next], gbits_next};
            display_en   <= (cnt_next >= CNT_BLANK);
            display_ctrl <= idx_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
module tb_seg_scan_display;

    localparam int CLK_DIV = 4;
    localparam int BLANK   = 1;
    localparam int FRAME   = 8 * CLK_DIV;

    logic        CP = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = 32'h0;
    logic        update = 1'b0;
    logic [7:0]  dp_mask = 8'h00;
    logic [7:0]  display_seg;
    logic        display_en;
    logic [2:0]  display_ctrl;
    logic        pending;

    int checks = 0;
    int failures = 0;

    seg_scan_display #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
        .CP(CP), .reset(reset), .data(data), .update(update), .dp_mask(dp_mask),
        .display_seg(display_seg), .display_en(display_en),
        .display_ctrl(display_ctrl), .pending(pending)
    );

    always #5 CP = ~CP;

    // Reference model: t counts clock edges since reset; slot/cnt follow from t.
    int          t = 0;
    logic [31:0] m_shown = 0, m_pend_val = 0;
    bit          m_pend = 0, m_rst = 1;
    logic [7:0]  m_dp = 0;

    function automatic logic [6:0] hex_ref(input logic [3:0] n);
        logic [6:0] tbl [16];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return tbl[n];
    endfunction

    function automatic logic [7:0] exp_seg(input logic [31:0] v, input int slot, input logic [7:0] dp);
        logic [6:0] g;
        g = hex_ref(v[slot*4 +: 4]);
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        if (slot != 0 && (v >> (4 * slot)) == 32'h0) g = 7'h00;
`endif
        return {dp[slot], g};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d actual=%h expected=%h", name, t, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CP);
        if (reset) begin
            t = 0; m_shown = 0; m_pend_val = 0; m_pend = 0; m_rst = 1;
        end else begin
            if ((t % FRAME) == FRAME - 1) begin
                if (update) m_shown = data;
                else if (m_pend) m_shown = m_pend_val;
                m_pend = 0;
            end else if (update) begin
                m_pend = 1;
            end
            if (update) m_pend_val = data;
            t++;
            m_rst = 0;
        end
        m_dp = dp_mask;
        @(negedge CP);
        if (m_rst) begin
            check("model_seg", {24'h0, display_seg}, 32'h0);
            check("model_en", {31'h0, display_en}, 32'h0);
            check("model_ctrl", {29'h0, display_ctrl}, 32'h0);
        end else begin
            check("model_seg", {24'h0, display_seg},
                  {24'h0, exp_seg(m_shown, (t / CLK_DIV) % 8, m_dp)});
            check("model_en", {31'h0, display_en}, {31'h0, ((t % CLK_DIV) >= BLANK)});
            check("model_ctrl", {29'h0, display_ctrl}, 32'((t / CLK_DIV) % 8));
        end
        check("model_pending", {31'h0, pending}, {31'h0, m_pend});
    endtask

    // Capture a value and run until it is committed (frame start).
    task automatic commit_value(input logic [31:0] v);
        int n;
        data = v; update = 1'b1;
        tick();
        update = 1'b0;
        n = 0;
        while (pending && n < 3 * FRAME) begin
            tick();
            n++;
        end
        check("commit_timeout", {31'h0, pending}, 32'h0);
        check("commit_frame_start", 32'(t % FRAME), 32'h0);
    endtask

    typedef struct {
        logic [31:0] val;
        logic [7:0]  dp;
        logic [7:0]  seg [8];
    } vec_t;

    vec_t vecs [5];

    initial begin
        vecs[0] = '{32'h70020402, 8'h00, '{8'h5B, 8'h3F, 8'h66, 8'h3F, 8'h5B, 8'h3F, 8'h3F, 8'h07}};
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        vecs[1] = '{32'h00000000, 8'h81, '{8'hBF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80}};
        vecs[2] = '{32'h00000402, 8'h00, '{8'h5B, 8'h3F, 8'h66, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
`else
        vecs[1] = '{32'h00000000, 8'h81, '{8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'hBF}};
        vecs[2] = '{32'h00000402, 8'h00, '{8'h5B, 8'h3F, 8'h66, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h3F}};
`endif
        vecs[3] = '{32'h89ABCDEF, 8'hFF, '{8'hF1, 8'hF9, 8'hDE, 8'hB9, 8'hFC, 8'hF7, 8'hEF, 8'hFF}};
        vecs[4] = '{32'h11111111, 8'h00, '{8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06, 8'h06}};

        reset = 1'b1;
        repeat (3) tick();
        check("reset_seg", {24'h0, display_seg}, 32'h0);
        check("reset_pending", {31'h0, pending}, 32'h0);
        reset = 1'b0;

        // Table-driven frames: commit each value, then inspect every slot.
        foreach (vecs[v]) begin
            dp_mask = vecs[v].dp;
            commit_value(vecs[v].val);
            for (int s = 0; s < 8; s++) begin
                check("tbl_slot_blank", {31'h0, display_en}, 32'h0);
                repeat (CLK_DIV - 1) tick();
                check("tbl_seg", {24'h0, display_seg}, {24'h0, vecs[v].seg[s]});
                check("tbl_ctrl", {29'h0, display_ctrl}, 32'(s));
                check("tbl_en", {31'h0, display_en}, 32'h1);
                tick();
            end
        end

        // Tear-free: update during digit 3 must not disturb the current frame.
        dp_mask = 8'h00;
        commit_value(32'h0);
        while (display_ctrl != 3'd3) tick();
        data = 32'h11111111; update = 1'b1;
        tick();
        update = 1'b0;
        check("tear_pending", {31'h0, pending}, 32'h1);
        while ((t % FRAME) != 0) begin
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
            check("tear_old_seg", {24'h0, display_seg}, 32'h00);
`else
            check("tear_old_seg", {24'h0, display_seg}, 32'h3F);
`endif
            tick();
        end
        check("tear_pending_clr", {31'h0, pending}, 32'h0);
        repeat (FRAME) begin
            check("tear_new_seg", {24'h0, display_seg}, 32'h06);
            tick();
        end

        // Collision: second update on the frame_end edge wins via bypass.
        repeat (3) tick();
        data = 32'hAAAAAAAA; update = 1'b1;
        tick();
        update = 1'b0;
        while ((t % FRAME) != FRAME - 1) tick();
        data = 32'hBBBBBBBB; update = 1'b1;
        tick();
        update = 1'b0;
        check("coll_pending", {31'h0, pending}, 32'h0);
        repeat (FRAME) begin
            check("coll_seg", {24'h0, display_seg}, 32'h7C);
            tick();
        end

        // Decimal point changed mid-frame shows up on the following slot.
        commit_value(32'h0);
        while (display_ctrl != 3'd2) tick();
        tick();
        dp_mask = 8'hFF;
        while (display_ctrl != 3'd3) tick();
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
        check("dp_live", {24'h0, display_seg}, 32'h80);
`else
        check("dp_live", {24'h0, display_seg}, 32'hBF);
`endif
        dp_mask = 8'h00;

        // Reset mid-scan and mid-pending.
        commit_value(32'hFFFFFFFF);
        while (display_ctrl != 3'd4) tick();
        data = 32'h12345678; update = 1'b1;
        tick();
        update = 1'b0;
        reset = 1'b1;
        repeat (5) begin
            tick();
            check("rst_seg", {24'h0, display_seg}, 32'h00);
            check("rst_en", {31'h0, display_en}, 32'h0);
            check("rst_ctrl", {29'h0, display_ctrl}, 32'h0);
            check("rst_pending", {31'h0, pending}, 32'h0);
        end
        reset = 1'b0;
        repeat (CLK_DIV - 1) tick();
        check("rst_restart_ctrl", {29'h0, display_ctrl}, 32'h0);
        check("rst_restart_seg", {24'h0, display_seg}, 32'h3F);
        tick();
        check("rst_slot1_ctrl", {29'h0, display_ctrl}, 32'h1);
        check("rst_slot1_en", {31'h0, display_en}, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            update = ($urandom_range(0, 19) == 0);
            data = $urandom;
            if ($urandom_range(0, 15) == 0) dp_mask = 8'($urandom);
            reset = ($urandom_range(0, 599) == 0);
            tick();
        end
        reset = 1'b0; update = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream display stage for the board-level barrel-shifter wrapper. Consumes the 32-bit result word and time-multiplexes it as 8 hex digits onto the board's shared 7-segment bus.
- Drives display_seg, display_en and display_ctrl directly.
- Holds a tear-free shadow copy of the value, so a digit never changes in the middle of a scan frame.

Parameters:
- CLK_DIV, 50000: CP cycles per digit slot; must be at least 2.
- BLANK_CYCLES, 2: anti-ghosting blank at the start of each slot; must satisfy 1 ≤ BLANK_CYCLES < CLK_DIV.

Ports:
- CP  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- data  in  32  value to display; digit i shows data[4i+3:4i].
- update  in  1  one-cycle strobe; captures data on this edge.
- dp_mask  in  8  decimal-point enable per digit; sampled live, not shadowed.
- display_seg  out  8  segment bits {dp,g,f,e,d,c,b,a}; active-high.
- display_en  out  1  digit-driver enable; active-high.
- display_ctrl  out  3  index of the selected digit.
- pending  out  1  a captured value is waiting for the frame boundary.

Behaviour:
- Clocking and reset: single clock CP. Reset is synchronous and active-high.
- Reset values:
  - cnt = 0, idx = 0, shown = 0, pend_val = 0, pending = 0.
  - display_seg = 8'h00, display_en = 0, display_ctrl = 3'd0.
  - Reset asserted mid-scan or mid-pending discards all state on the next edge.
- Prescaler: cnt counts 0..CLK_DIV-1 and wraps to 0. slot_end = (cnt == CLK_DIV-1).
- Digit index: idx advances on slot_end and wraps 7 to 0. frame_end = slot_end && idx == 7.
- Capture path:
  - update: pend_val <= data and pending <= 1.
  - A later update before frame_end overwrites pend_val; last write wins.
- Shadow commit on frame_end:
  - If update is high in the same cycle: shown <= data (bypass) and pending <= 0.
  - Else if pending: shown <= pend_val and pending <= 0.
  - Else: shown is unchanged.
  - shown changes only at frame_end.
- Outputs are registered and computed from next-state values, so all three always describe the same slot:
  - display_ctrl <= idx_next.
  - display_en <= (cnt_next >= BLANK_CYCLES).
  - display_seg <= {dp_mask[idx_next], hex7(shown_next[4*idx_next +: 4])}.
- hex7 encodes {g..a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Timing: a full frame is 8*CLK_DIV cycles. Latency from update to visible change is at most one frame plus 1 cycle.
- display_en is low for exactly BLANK_CYCLES cycles at the start of every slot, including the first slot after reset.

Optional Feature:
- Macro: SEG_SCAN_LEADING_ZERO_BLANK_EN.
- Defined:
  - A digit is suppressed when it and every higher digit of shown are zero: segment bits {g..a} = 0.
  - Digit 0 is never suppressed.
  - dp is still driven from dp_mask.
  - Suppression is evaluated on shown_next, in the same register stage.
- Undefined: all 8 digits are always shown, including leading zeros.

Test Plan:
- Reset: hold reset 5 cycles mid-scan with shown = 32'hFFFFFFFF -> next edge gives display_seg = 00, display_en = 0, display_ctrl = 0, pending = 0; after release, scanning restarts at digit 0 with cnt = 0.
- Basic frame (CLK_DIV = 4, BLANK_CYCLES = 1): update with data = 32'h70020402 -> pending = 1 until frame_end. Following frame shows digits 0..7 as 5B, 3F, 66, 3F, 5B, 3F, 3F, 07. Each slot: en = 0 for 1 cycle, then 1 for 3 cycles.
- Tear-free: update 32'h11111111 during digit 3 of a frame showing 32'h0 -> digits 3..7 of that frame still show 3F; next frame shows all 06; pending clears at frame_end.
- Collision: update 32'hAAAAAAAA, then update 32'hBBBBBBBB coinciding with frame_end -> next frame shows all 7C; pending = 0; AAAAAAAA is never displayed.
- Decimal points: dp_mask = 8'h81 with shown = 0 -> digits 0 and 7 output BF, the others 3F; changing dp_mask mid-frame takes effect at the next slot.
- Optional feature (macro defined): shown = 32'h00000402 -> digits 0..2 show 5B, 3F, 66 and digits 3..7 show 00. shown = 0 -> digit 0 shows 3F and the others 00. With the macro undefined, the same cases show 3F on every zero digit.
